// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with selectable first-word-fall-through or registered-read
// output, almost-full/almost-empty thresholds, synchronous flush and sticky overflow.
module fifo_sync_ext #(
  parameter int Nb       = 8,
  parameter int M        = 2,
  parameter bit FWFT     = 1'b1,
  parameter int AF_LEVEL = (1 << M) - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [Nb-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [Nb-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          flush,
  input  logic          clear_overflow,
  output logic [M:0]    count,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow
);

  localparam int N = 1 << M;
  localparam logic [M:0] AF_LVL = (M+1)'(AF_LEVEL);
  localparam logic [M:0] AE_LVL = (M+1)'(AE_LEVEL);

  // Handshake: a write transfers on an edge where in_valid && in_ready; a read
  // transfers where out_ready is high and the FIFO is non-empty. flush and reset
  // override both transfers in the same cycle.

  logic [Nb-1:0] mem [N];
  logic [M:0]    wr_ptr;
  logic [M:0]    rd_ptr;
  logic          empty;
  logic          full;
  logic          wr_en;
  logic          rd_en;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr == {~rd_ptr[M], rd_ptr[M-1:0]});
  assign count    = wr_ptr - rd_ptr;
  assign in_ready = !full;

  assign wr_en = in_valid && !full && !flush;
  assign rd_en = out_ready && !empty && !flush;

  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[M-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Set wins over clear so a fresh overflow is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (in_valid && full) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign out_valid = !empty;
      assign out_data  = mem[rd_ptr[M-1:0]];
    end else begin : g_reg
      logic [Nb-1:0] out_data_q;
      logic          out_valid_q;

      // out_data keeps its last word through flush; only the valid bit drops.
      always_ff @(posedge clk) begin
        if (reset) begin
          out_data_q  <= '0;
          out_valid_q <= 1'b0;
        end else if (flush) begin
          out_valid_q <= 1'b0;
        end else if (out_ready) begin
          if (!empty) begin
            out_data_q  <= mem[rd_ptr[M-1:0]];
            out_valid_q <= 1'b1;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
      end

      assign out_valid = out_valid_q;
      assign out_data  = out_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_ext.sv
// Bench for fifo_sync_ext: a FWFT instance checked through a popping scoreboard,
// and a registered-read instance checked with directed expected values.
module tb_fifo_sync_ext;

  logic clk;
  logic reset;

  logic [7:0] a_in_data, a_out_data;
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic       a_flush, a_clear_overflow, a_almost_full, a_almost_empty, a_overflow;
  logic [2:0] a_count;

  logic [7:0] b_in_data, b_out_data;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic       b_flush, b_clear_overflow, b_almost_full, b_almost_empty, b_overflow;
  logic [2:0] b_count;

  logic [7:0] exp_q[$];
  int n_cmp;
  int n_err;

  fifo_sync_ext #(.Nb(8), .M(2), .FWFT(1'b1)) u_fwft (
    .clk(clk), .reset(reset),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .flush(a_flush), .clear_overflow(a_clear_overflow), .count(a_count),
    .almost_full(a_almost_full), .almost_empty(a_almost_empty), .overflow(a_overflow)
  );

  fifo_sync_ext #(.Nb(8), .M(2), .FWFT(1'b0)) u_reg (
    .clk(clk), .reset(reset),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .flush(b_flush), .clear_overflow(b_clear_overflow), .count(b_count),
    .almost_full(b_almost_full), .almost_empty(b_almost_empty), .overflow(b_overflow)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [7:0] d, input bit push);
    a_in_data  = d;
    a_in_valid = 1'b1;
    if (push) exp_q.push_back(d);
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic b_write(input logic [7:0] d);
    b_in_data  = d;
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
  endtask

  // Scoreboard monitor: every FWFT pop is compared with the head of exp_q.
  always @(negedge clk) begin
    if (!reset && !a_flush && a_out_valid && a_out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got %h expected no data at %0t", a_out_data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (a_out_data !== e) begin
          n_err++;
          $display("FAIL pop_data: got %h expected %h at %0t", a_out_data, e, $time);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    {a_in_data, a_in_valid, a_out_ready, a_flush, a_clear_overflow} = '0;
    {b_in_data, b_in_valid, b_out_ready, b_flush, b_clear_overflow} = '0;
    repeat (2) step();
    reset = 1'b0;

    // Reset state
    check("rst_count", 8'(a_count), 8'd0);
    check("rst_in_ready", 8'(a_in_ready), 8'd1);
    check("rst_ae", 8'(a_almost_empty), 8'd1);
    check("rst_af", 8'(a_almost_full), 8'd0);
    check("rst_out_valid", 8'(a_out_valid), 8'd0);
    check("rst_overflow", 8'(a_overflow), 8'd0);
    check("rst_b_out_data", b_out_data, 8'h00);
    check("rst_b_out_valid", 8'(b_out_valid), 8'd0);

    // Fill with out_ready low, then drain back-to-back
    for (int i = 0; i < 4; i++) begin
      a_write(8'((i + 1) * 8'h11), 1'b1);
      check("fill_count", 8'(a_count), 8'(i + 1));
      check("fill_af", 8'(a_almost_full), 8'(i + 1 >= 3));
      check("fill_ae", 8'(a_almost_empty), 8'(i + 1 <= 1));
      check("fill_in_ready", 8'(a_in_ready), 8'(i + 1 < 4));
    end
    a_out_ready = 1'b1;
    repeat (4) step();
    a_out_ready = 1'b0;
    check("drain_out_valid", 8'(a_out_valid), 8'd0);
    check("drain_count", 8'(a_count), 8'd0);

    // Write-to-visible latency on an empty FIFO
    a_in_data  = 8'hA5;
    a_in_valid = 1'b1;
    exp_q.push_back(8'hA5);
    check("lat_same_cycle", 8'(a_out_valid), 8'd0);
    step();
    a_in_valid = 1'b0;
    check("lat_next_valid", 8'(a_out_valid), 8'd1);
    check("lat_next_data", a_out_data, 8'hA5);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;

    // Full boundary: read goes, write dropped, overflow set and sticky
    for (int i = 0; i < 4; i++) a_write(8'(8'h50 + i), 1'b1);
    a_in_data   = 8'h99;
    a_in_valid  = 1'b1;
    a_out_ready = 1'b1;
    step();
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    check("full_rd_count", 8'(a_count), 8'd3);
    check("full_overflow", 8'(a_overflow), 8'd1);
    step();
    check("ovf_sticky", 8'(a_overflow), 8'd1);
    a_write(8'h54, 1'b1);
    check("refill_count", 8'(a_count), 8'd4);
    a_in_data        = 8'h98;
    a_in_valid       = 1'b1;
    a_clear_overflow = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("ovf_set_beats_clear", 8'(a_overflow), 8'd1);
    step();
    a_clear_overflow = 1'b0;
    check("ovf_cleared", 8'(a_overflow), 8'd0);
    a_out_ready = 1'b1;
    repeat (4) step();
    a_out_ready = 1'b0;
    check("full_drain_count", 8'(a_count), 8'd0);

    // Continuous streaming across pointer wraps
    a_write(8'h00, 1'b1);
    a_write(8'h01, 1'b1);
    a_in_valid  = 1'b1;
    a_out_ready = 1'b1;
    for (int i = 2; i < 40; i++) begin
      a_in_data = 8'(i);
      exp_q.push_back(8'(i));
      step();
      check("stream_count", 8'(a_count), 8'd2);
    end
    a_in_valid = 1'b0;
    repeat (2) step();
    a_out_ready = 1'b0;
    check("stream_overflow", 8'(a_overflow), 8'd0);
    check("stream_end_count", 8'(a_count), 8'd0);

    // Flush mid-operation with overflow set
    a_write(8'h61, 1'b1);
    for (int i = 2; i < 5; i++) a_write(8'(8'h60 + i), 1'b0);
    a_write(8'h65, 1'b0);
    check("pre_flush_ovf", 8'(a_overflow), 8'd1);
    a_out_ready = 1'b1;
    step();
    check("pre_flush_count", 8'(a_count), 8'd3);
    a_flush    = 1'b1;
    a_in_data  = 8'h77;
    a_in_valid = 1'b1;
    step();
    {a_flush, a_in_valid, a_out_ready} = '0;
    check("flush_count", 8'(a_count), 8'd0);
    check("flush_out_valid", 8'(a_out_valid), 8'd0);
    check("flush_in_ready", 8'(a_in_ready), 8'd1);
    check("flush_overflow", 8'(a_overflow), 8'd1);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) a_write(8'(8'h81 + i), 1'b0);
    check("pre_rst_count", 8'(a_count), 8'd3);
    reset       = 1'b1;
    a_in_data   = 8'h88;
    a_in_valid  = 1'b1;
    a_out_ready = 1'b1;
    step();
    reset = 1'b0;
    {a_in_valid, a_out_ready} = '0;
    check("mrst_count", 8'(a_count), 8'd0);
    check("mrst_out_valid", 8'(a_out_valid), 8'd0);
    check("mrst_in_ready", 8'(a_in_ready), 8'd1);
    check("mrst_overflow", 8'(a_overflow), 8'd0);
    check("mrst_ae", 8'(a_almost_empty), 8'd1);
    check("mrst_af", 8'(a_almost_full), 8'd0);

    // Registered-read instance
    b_write(8'h01);
    b_write(8'h02);
    check("b_preload_count", 8'(b_count), 8'd2);
    check("b_preload_valid", 8'(b_out_valid), 8'd0);
    b_out_ready = 1'b1;
    step();
    check("b_rd1_valid", 8'(b_out_valid), 8'd1);
    check("b_rd1_data", b_out_data, 8'h01);
    check("b_rd1_count", 8'(b_count), 8'd1);
    step();
    check("b_rd2_valid", 8'(b_out_valid), 8'd1);
    check("b_rd2_data", b_out_data, 8'h02);
    check("b_rd2_count", 8'(b_count), 8'd0);
    step();
    check("b_rd3_valid", 8'(b_out_valid), 8'd0);
    check("b_rd3_data", b_out_data, 8'h02);
    b_out_ready = 1'b0;
    b_write(8'h03);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    check("b_rd4_data", b_out_data, 8'h03);
    repeat (2) step();
    check("b_hold_valid", 8'(b_out_valid), 8'd1);
    check("b_hold_data", b_out_data, 8'h03);
    b_in_data   = 8'h04;
    b_in_valid  = 1'b1;
    b_out_ready = 1'b1;
    step();
    b_in_valid = 1'b0;
    check("b_empty_rw_valid", 8'(b_out_valid), 8'd0);
    check("b_empty_rw_count", 8'(b_count), 8'd1);
    step();
    b_out_ready = 1'b0;
    check("b_rd5_data", b_out_data, 8'h04);
    b_write(8'h05);
    b_flush = 1'b1;
    step();
    b_flush = 1'b0;
    check("b_flush_valid", 8'(b_out_valid), 8'd0);
    check("b_flush_data", b_out_data, 8'h04);
    check("b_flush_count", 8'(b_count), 8'd0);

    step();
    check("sb_queue_empty", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
